countdown_engine: RTL and testbench
===================================

# countdown_engine

Countdown datapath that consumes the mm:ss BCD digits loaded by the egg-timer set-up logic and counts them down to 00:00 once per second. It sits between the digit-setting front end (switch entry and controller states) and the four 7-segment decoders and LED bank. It owns the 1 Hz prescaler, the BCD borrow chain, the end-of-count alarm and the LED flash cadence.

## Interface
- TICKS_PER_SEC, default 50000000: CLOCK_50 cycles per one-second decrement; must be ≥2.
- FLASH_TICKS, default 25000000: CLOCK_50 cycles per FLASH half-period in ALARM; must be ≥1.
- CLOCK_50  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  level; load D_IN into the count.
- D_IN  in  16  {HiMin, LoMin, HiSec, LoSec}, 4-bit BCD each.
- START  in  1  level; begin or resume counting.
- PAUSE  in  1  level; freeze counting.
- ACK  in  1  level; clear the alarm.
- Q  out  16  current count, same packing as D_IN; drives the four display decoders.
- RUNNING  out  1  high while in RUN.
- ALARM  out  1  high while in ALARM.
- DONE  out  1  one-cycle pulse on reaching 00:00.
- FLASH  out  1  alarm blink (drives all LEDR); low outside ALARM.

## Operation
- States: IDLE, RUN, PAUSED, ALARM. Reset forces IDLE, Q=0000, prescaler=0, flash counter=0, and DONE/FLASH/RUNNING/ALARM=0.
- Input priority within a cycle: ACK > LOAD > PAUSE > START.
- LOAD is accepted in IDLE and PAUSED and ignored in RUN and ALARM. The state is unchanged.
  - On load, clamp each digit: LoSec>9→9, HiSec>5→5, LoMin>9→9, HiMin>9→9.
- START:
  - From IDLE or PAUSED with Q≠0000: go to RUN and clear the prescaler.
  - With Q=0000: ignored.
- PAUSE in RUN: go to PAUSED. The prescaler holds its value, and a tick due in the same cycle is discarded.
- Tick: in RUN, the prescaler counts 0..TICKS_PER_SEC-1. Its wrap is the tick.
- Decrement on tick, as a borrow chain:
  - LoSec 0→9 with borrow.
  - HiSec 0→5 with borrow.
  - LoMin 0→9 with borrow.
  - HiMin decrements.
  - Example: 10:00→09:59, 01:00→00:59.
- Terminal count: a tick that produces 0000 moves RUN→ALARM in the same edge.
  - DONE is high for exactly the first ALARM cycle.
  - Q stays 0000 and never wraps to 99:59.
- ALARM:
  - FLASH=1 on entry, then toggles every FLASH_TICKS cycles.
  - ACK → IDLE with FLASH=0 and Q held at 0000.
  - LOAD, START and PAUSE are ignored.
- ACK in any other state → IDLE with Q unchanged.
- Reset asserted mid-count or mid-alarm: immediate asynchronous return to reset values. No DONE pulse is generated.

## Timing
- All outputs are registered. No combinational input-to-output path.
- LOAD sampled at edge N → Q valid after edge N.
- START at edge N → RUNNING=1 after N. The first decrement occurs at edge N+TICKS_PER_SEC, then every TICKS_PER_SEC cycles.
- Resume after PAUSE: START clears the prescaler, so the next decrement is a full TICKS_PER_SEC after resume.
- Total run time from START to DONE = (seconds in Q)·TICKS_PER_SEC cycles.
- DONE rises in the same edge that Q becomes 0000 and falls one cycle later.
- FLASH half-period is exactly FLASH_TICKS cycles. The flash counter restarts on each ALARM entry.

## Test plan
Bench parameters for all scenarios: TICKS_PER_SEC=4, FLASH_TICKS=2.

- Load and count: LOAD D_IN=0x0003, then START. Q steps 0002, 0001, 0000 at 4, 8 and 12 cycles after START. DONE is a single pulse at cycle 12. ALARM=1 and FLASH pattern is 1,1,0,0,1,…
- Borrow chain: load 0x1000, START. After 4 cycles Q=0959. Load 0x0100 → after 4 cycles Q=0059.
- Clamping: LOAD D_IN=0xFFFF. Q=9959. A LOAD asserted while in RUN leaves Q unchanged.
- Pause/resume: load 0x0010, START, PAUSE after 6 cycles (Q=0009). Hold PAUSE 20 cycles; Q is held at 0009. START again; Q=0008 exactly 4 cycles later.
- Edge cases:
  - START with Q=0000 → stays IDLE with RUNNING=0.
  - ACK in ALARM → IDLE, FLASH=0, Q=0000.
  - PAUSE and START in the same cycle → PAUSED.
- Reset mid-operation: drop RESET_N for one cycle during RUN with Q=0005. All outputs go to 0 asynchronously, and Q=0000 with no DONE pulse.

Source files
------------

// File: rtl/countdown_engine.sv
// Egg-timer countdown datapath: 1 Hz prescaler, mm:ss BCD borrow chain,
// end-of-count alarm with DONE pulse and LED flash cadence.
module countdown_engine #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FLASH_TICKS   = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [15:0] D_IN,
  input  logic        START,
  input  logic        PAUSE,
  input  logic        ACK,
  output logic [15:0] Q,
  output logic        RUNNING,
  output logic        ALARM,
  output logic        DONE,
  output logic        FLASH
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_ALARM
  } state_t;

  state_t          r_state;
  logic [15:0]     r_q;
  logic [PW-1:0]   r_presc;
  logic [FW-1:0]   r_flash_cnt;
  logic            r_done;
  logic            r_flash;

  logic [15:0]     w_q_dec;
  logic            w_q_zero;
  logic            w_tick;

  // Each digit is limited to its legal range: minutes 0..99, seconds 0..59.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] d);
    logic [3:0] hm, lm, hs, ls;
    hm = (d[15:12] > 4'd9) ? 4'd9 : d[15:12];
    lm = (d[11:8]  > 4'd9) ? 4'd9 : d[11:8];
    hs = (d[7:4]   > 4'd5) ? 4'd5 : d[7:4];
    ls = (d[3:0]   > 4'd9) ? 4'd9 : d[3:0];
    return {hm, lm, hs, ls};
  endfunction

  // One-second decrement; 00:00 saturates so the count can never wrap to 99:59.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v != 16'h0000) begin
      if (v[3:0] != 4'd0) begin
        r[3:0] = v[3:0] - 4'd1;
      end else begin
        r[3:0] = 4'd9;
        if (v[7:4] != 4'd0) begin
          r[7:4] = v[7:4] - 4'd1;
        end else begin
          r[7:4] = 4'd5;
          if (v[11:8] != 4'd0) begin
            r[11:8] = v[11:8] - 4'd1;
          end else begin
            r[11:8]  = 4'd9;
            r[15:12] = v[15:12] - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  assign w_q_dec  = bcd_dec(r_q);
  assign w_q_zero = (r_q == 16'h0000);
  assign w_tick   = (r_presc == PRESC_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_q         <= 16'h0000;
      r_presc     <= '0;
      r_flash_cnt <= '0;
      r_done      <= 1'b0;
      r_flash     <= 1'b0;
    end else begin
      // NOTE: DONE defaults low every cycle so it can only ever be a one-cycle pulse.
      r_done <= 1'b0;
      if (ACK) begin
        r_state <= S_IDLE;
        r_flash <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_PAUSED: begin
            if (LOAD) begin
              r_q <= bcd_clamp(D_IN);
            end else if (!PAUSE && START && !w_q_zero) begin
              r_state <= S_RUN;
              r_presc <= '0;
            end
          end
          S_RUN: begin
            // Pausing freezes the prescaler and drops any tick due this cycle.
            if (PAUSE) begin
              r_state <= S_PAUSED;
            end else if (w_tick) begin
              r_presc <= '0;
              r_q     <= w_q_dec;
              if (w_q_dec == 16'h0000) begin
                r_state     <= S_ALARM;
                r_done      <= 1'b1;
                r_flash     <= 1'b1;
                r_flash_cnt <= '0;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          S_ALARM: begin
            if (r_flash_cnt == FLASH_LAST) begin
              r_flash_cnt <= '0;
              r_flash     <= ~r_flash;
            end else begin
              r_flash_cnt <= r_flash_cnt + FW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Q       = r_q;
  assign RUNNING = (r_state == S_RUN);
  assign ALARM   = (r_state == S_ALARM);
  assign DONE    = r_done;
  assign FLASH   = r_flash;

endmodule

// File: tb/tb_countdown_engine.sv
// Directed bench for countdown_engine with TICKS_PER_SEC=4, FLASH_TICKS=2:
// a vector table for the main flow plus hand-written pause and reset sequences.
module tb_countdown_engine;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        LOAD;
  logic [15:0] D_IN;
  logic        START;
  logic        PAUSE;
  logic        ACK;
  logic [15:0] Q;
  logic        RUNNING;
  logic        ALARM;
  logic        DONE;
  logic        FLASH;

  int tests_run;
  int tests_failed;

  countdown_engine #(
    .TICKS_PER_SEC(4),
    .FLASH_TICKS  (2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .LOAD    (LOAD),
    .D_IN    (D_IN),
    .START   (START),
    .PAUSE   (PAUSE),
    .ACK     (ACK),
    .Q       (Q),
    .RUNNING (RUNNING),
    .ALARM   (ALARM),
    .DONE    (DONE),
    .FLASH   (FLASH)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One applied record: inputs held for one edge, then wait_n idle edges, then compare.
  typedef struct {
    string       name;
    logic        ld;
    logic [15:0] d;
    logic        st;
    logic        pa;
    logic        ak;
    int          wait_n;
    logic [15:0] q;
    logic        run;
    logic        alm;
    logic        dn;
    logic        fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic ld, input logic [15:0] d,
                              input logic st, input logic pa, input logic ak, input int wait_n,
                              input logic [15:0] q, input logic run, input logic alm,
                              input logic dn, input logic fl);
    vec_t v;
    v.name = name; v.ld = ld; v.d = d; v.st = st; v.pa = pa; v.ak = ak; v.wait_n = wait_n;
    v.q = q; v.run = run; v.alm = alm; v.dn = dn; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {12'h000, Q, RUNNING, ALARM, DONE, FLASH};
  endfunction

  function automatic logic [31:0] want(input logic [15:0] q, input logic run, input logic alm,
                                       input logic dn, input logic fl);
    return {12'h000, q, run, alm, dn, fl};
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_inputs();
    LOAD = 1'b0; D_IN = 16'h0000; START = 1'b0; PAUSE = 1'b0; ACK = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d);
    LOAD = 1'b1; D_IN = d;
    step();
    clear_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();
    RESET_N = 1'b0;
    repeat (2) step();
    check("reset_state", obs(), want(16'h0000, 0, 0, 0, 0));
    RESET_N = 1'b1;
    step();

    //            name              ld  d         st pa ak wait  q         run alm dn fl
    vecs.push_back(mk("load_0003",     1, 16'h0003, 0, 0, 0, 0, 16'h0003, 0, 0, 0, 0));
    vecs.push_back(mk("start_pre",     0, 16'h0000, 1, 0, 0, 3, 16'h0003, 1, 0, 0, 0));
    vecs.push_back(mk("tick_0002",     0, 16'h0000, 0, 0, 0, 0, 16'h0002, 1, 0, 0, 0));
    vecs.push_back(mk("tick_0001",     0, 16'h0000, 0, 0, 0, 3, 16'h0001, 1, 0, 0, 0));
    vecs.push_back(mk("tick_done",     0, 16'h0000, 0, 0, 0, 3, 16'h0000, 0, 1, 1, 1));
    vecs.push_back(mk("done_fall",     0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk("flash_0a",      0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("flash_0b",      0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("flash_1",       0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk("alarm_ld_ign",  1, 16'h1234, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk("alarm_st_ign",  0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("alarm_ack",     0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("start_zero",    0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("load_1000",     1, 16'h1000, 0, 0, 0, 0, 16'h1000, 0, 0, 0, 0));
    vecs.push_back(mk("start_1000",    0, 16'h0000, 1, 0, 0, 3, 16'h1000, 1, 0, 0, 0));
    vecs.push_back(mk("borrow_0959",   0, 16'h0000, 0, 0, 0, 0, 16'h0959, 1, 0, 0, 0));
    vecs.push_back(mk("run_ack",       0, 16'h0000, 0, 0, 1, 0, 16'h0959, 0, 0, 0, 0));
    vecs.push_back(mk("load_0100",     1, 16'h0100, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0));
    vecs.push_back(mk("start_0100",    0, 16'h0000, 1, 0, 0, 3, 16'h0100, 1, 0, 0, 0));
    vecs.push_back(mk("borrow_0059",   0, 16'h0000, 0, 0, 0, 0, 16'h0059, 1, 0, 0, 0));
    vecs.push_back(mk("run_ld_ign",    1, 16'h0003, 0, 0, 0, 0, 16'h0059, 1, 0, 0, 0));
    vecs.push_back(mk("run_ack2",      0, 16'h0000, 0, 0, 1, 0, 16'h0059, 0, 0, 0, 0));
    vecs.push_back(mk("clamp_ffff",    1, 16'hFFFF, 0, 0, 0, 0, 16'h9959, 0, 0, 0, 0));
    vecs.push_back(mk("clamp_f5a7",    1, 16'hF5A7, 0, 0, 0, 0, 16'h9557, 0, 0, 0, 0));
    vecs.push_back(mk("load_0005",     1, 16'h0005, 0, 0, 0, 0, 16'h0005, 0, 0, 0, 0));
    vecs.push_back(mk("start_0005",    0, 16'h0000, 1, 0, 0, 1, 16'h0005, 1, 0, 0, 0));
    vecs.push_back(mk("pause_and_st",  0, 16'h0000, 1, 1, 0, 0, 16'h0005, 0, 0, 0, 0));
    vecs.push_back(mk("resume_pre",    0, 16'h0000, 1, 0, 0, 3, 16'h0005, 1, 0, 0, 0));
    vecs.push_back(mk("resume_tick",   0, 16'h0000, 0, 0, 0, 0, 16'h0004, 1, 0, 0, 0));
    vecs.push_back(mk("run_ack3",      0, 16'h0000, 0, 0, 1, 0, 16'h0004, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      LOAD = vecs[i].ld; D_IN = vecs[i].d; START = vecs[i].st;
      PAUSE = vecs[i].pa; ACK = vecs[i].ak;
      step();
      clear_inputs();
      repeat (vecs[i].wait_n) step();
      check(vecs[i].name, obs(),
            want(vecs[i].q, vecs[i].run, vecs[i].alm, vecs[i].dn, vecs[i].fl));
    end

    // PAUSE landing on the tick edge discards that tick.
    do_load(16'h0002);
    START = 1'b1; step(); START = 1'b0;
    repeat (3) step();
    PAUSE = 1'b1; step(); PAUSE = 1'b0;
    check("pause_on_tick", obs(), want(16'h0002, 0, 0, 0, 0));
    ACK = 1'b1; step(); ACK = 1'b0;

    // Pause/resume: Q held through a long pause, full second after resume.
    begin
      int moved;
      moved = 0;
      do_load(16'h0010);
      START = 1'b1; step(); START = 1'b0;
      repeat (5) step();
      check("pr_first_tick", obs(), want(16'h0009, 1, 0, 0, 0));
      PAUSE = 1'b1;
      for (int k = 0; k < 20; k++) begin
        step();
        if (Q !== 16'h0009 || RUNNING !== 1'b0) moved++;
      end
      PAUSE = 1'b0;
      check("pr_held_cycles", 32'(moved), 32'd0);
      check("pr_paused", obs(), want(16'h0009, 0, 0, 0, 0));
      START = 1'b1; step(); START = 1'b0;
      repeat (3) step();
      check("pr_resume_pre", obs(), want(16'h0009, 1, 0, 0, 0));
      step();
      check("pr_resume_tick", obs(), want(16'h0008, 1, 0, 0, 0));
      ACK = 1'b1; step(); ACK = 1'b0;
    end

    // Asynchronous reset mid-count, then confirm no DONE pulse follows.
    begin
      int stray;
      stray = 0;
      do_load(16'h0005);
      START = 1'b1; step(); START = 1'b0;
      repeat (2) step();
      check("rst_pre", obs(), want(16'h0005, 1, 0, 0, 0));
      #3 RESET_N = 1'b0;
      #1;
      check("rst_async", obs(), want(16'h0000, 0, 0, 0, 0));
      step();
      check("rst_held", obs(), want(16'h0000, 0, 0, 0, 0));
      RESET_N = 1'b1;
      for (int k = 0; k < 25; k++) begin
        step();
        if (DONE !== 1'b0 || ALARM !== 1'b0 || Q !== 16'h0000) stray++;
      end
      check("rst_no_done", 32'(stray), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
